ex_stage: RTL and testbench

- Execute stage of the 5-stage core. Directly consumes the ID/EX pipeline register outputs.
- Performs operand forwarding, ALU operation, branch resolution and an optional iterative 32-cycle multiply.
- Registers all results into the EX/MEM pipeline register.
- Drives stall_o back to fetch/decode during multi-cycle ops, and flush_o on taken branches.

---
 rtl/ex_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage core.
// Forwards operands from EX/MEM and WB, runs the ALU, resolves conditional
// branches, and registers everything into the EX/MEM pipeline register.
// Optional feature macro: EX_MUL_EN. When it is defined, op 1010 runs an
// iterative 32-cycle shift-add multiply that stalls the front end. When it
// is undefined, op 1010 is a single-cycle op whose result is 0, and stall_o
// is tied to 0.
module ex_stage #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [3:0]        ALUControl_i,
  input  logic [31:0]       imme_i,
  input  logic [31:0]       rdata1_i,
  input  logic [31:0]       rdata2_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic              wb_regwrite_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [31:0]       wb_wdata_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] branch_target_o,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic [31:0]       alu_result_o,
  output logic [31:0]       rdata2_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       instr_o
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  // EX/MEM register state behind the outputs
  logic              r_valid;
  logic              r_regwrite;
  logic [31:0]       r_result;
  logic [31:0]       r_rdata2;
  logic [4:0]        r_rd;
  logic [31:0]       r_instr;
  logic              r_flush;
  logic [ADDR_W-1:0] r_target;

  logic [31:0]       w_fwd_a;
  logic [31:0]       w_fwd_b;
  logic [31:0]       w_op_b;
  logic [4:0]        w_shamt;
  logic [31:0]       w_alu;
  logic              w_cond;
  logic              w_taken;
  logic              w_squash;
  logic              w_idle;
  logic              w_mul_start;
  logic              w_accept;
  logic [ADDR_W-1:0] w_target;

  assign valid_o         = r_valid;
  assign RegWrite_o      = r_regwrite;
  assign alu_result_o    = r_result;
  assign rdata2_o        = r_rdata2;
  assign rd_o            = r_rd;
  assign instr_o         = r_instr;
  assign flush_o         = r_flush;
  assign branch_target_o = r_target;

  // The instruction presented right after a taken branch is a wrong-path bubble.
  assign w_squash = r_flush;

  // Operand forwarding: the younger EX/MEM result wins over WB; x0 never forwards.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_fwd_a = rdata1_i;
    w_fwd_b = rdata2_i;
    if (r_valid && r_regwrite && (r_rd != 5'd0) && (r_rd == rs1_i))
      w_fwd_a = r_result;
    else if (wb_regwrite_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_i))
      w_fwd_a = wb_wdata_i;
    if (r_valid && r_regwrite && (r_rd != 5'd0) && (r_rd == rs2_i))
      w_fwd_b = r_result;
    else if (wb_regwrite_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_i))
      w_fwd_b = wb_wdata_i;
  end

  assign w_op_b  = ALUSrc_i ? imme_i : w_fwd_b;
  assign w_shamt = w_op_b[4:0];

  // Single-cycle ALU; MUL and unused encodings produce 0 here.
  always_comb begin
    w_alu = 32'd0;
    case (ALUControl_i)
      ALU_AND:  w_alu = w_fwd_a & w_op_b;
      ALU_OR:   w_alu = w_fwd_a | w_op_b;
      ALU_ADD:  w_alu = w_fwd_a + w_op_b;
      ALU_SUB:  w_alu = w_fwd_a - w_op_b;
      ALU_XOR:  w_alu = w_fwd_a ^ w_op_b;
      ALU_SLL:  w_alu = w_fwd_a << w_shamt;
      ALU_SRL:  w_alu = w_fwd_a >> w_shamt;
      ALU_SRA:  w_alu = 32'($signed(w_fwd_a) >>> w_shamt);
      ALU_SLT:  w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_op_b)};
      ALU_SLTU: w_alu = {31'd0, w_fwd_a < w_op_b};
      default:  w_alu = 32'd0;
    endcase
  end

  // Branch condition on the forwarded rs1/rs2, selected by funct3.
  always_comb begin
    w_cond = 1'b0;
    case (instr_i[14:12])
      3'b000:  w_cond = (w_fwd_a == w_fwd_b);
      3'b001:  w_cond = (w_fwd_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_fwd_a <  w_fwd_b);
      3'b111:  w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_target = addr_i + imme_i[ADDR_W-1:0];
  assign w_accept = valid_i && !w_squash && w_idle && !w_mul_start;
  assign w_taken  = w_accept && Branch_i && w_cond;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_prod;
  logic [31:0] r_m_rdata2;
  logic [4:0]  r_m_rd;
  logic [31:0] r_m_instr;
  logic        r_m_regwrite;
  logic        w_mul_done;

  // A branch carrying the MUL encoding resolves as a branch, never a multiply.
  assign w_mul_start = (r_state == S_IDLE) && valid_i && !w_squash &&
                       (ALUControl_i == ALU_MUL) && !Branch_i;
  assign w_idle      = (r_state == S_IDLE);
  assign w_mul_done  = (r_state == S_DONE);
  assign stall_o     = w_mul_start || (r_state == S_BUSY);

  // Multiply FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Multiply FSM next state: one BUSY cycle per multiplier bit, then DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_next_state = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Shift-add datapath; operands and destination are frozen at start so
  // later input changes during BUSY cannot disturb the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= 5'd0;
      r_mcand      <= 32'd0;
      r_mplier     <= 32'd0;
      r_prod       <= 32'd0;
      r_m_rdata2   <= 32'd0;
      r_m_rd       <= 5'd0;
      r_m_instr    <= 32'd0;
      r_m_regwrite <= 1'b0;
    end else if (w_mul_start) begin
      r_cnt        <= 5'd0;
      r_mcand      <= w_fwd_a;
      r_mplier     <= w_op_b;
      r_prod       <= 32'd0;
      r_m_rdata2   <= w_fwd_b;
      r_m_rd       <= rd_i;
      r_m_instr    <= instr_i;
      r_m_regwrite <= RegWrite_i;
    end else if (r_state == S_BUSY) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
    end
  end
`else
  assign w_mul_start = 1'b0;
  assign w_idle      = 1'b1;
  assign stall_o     = 1'b0;
`endif

  // EX/MEM capture: accepted op or finished multiply, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_result   <= 32'd0;
      r_rdata2   <= 32'd0;
      r_rd       <= 5'd0;
      r_instr    <= 32'd0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_regwrite <= RegWrite_i;
      r_result   <= w_alu;
      r_rdata2   <= w_fwd_b;
      r_rd       <= rd_i;
      r_instr    <= instr_i;
`ifdef EX_MUL_EN
    end else if (w_mul_done) begin
      r_valid    <= 1'b1;
      r_regwrite <= r_m_regwrite;
      r_result   <= r_prod;
      r_rdata2   <= r_m_rdata2;
      r_rd       <= r_m_rd;
      r_instr    <= r_m_instr;
`endif
    end else begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end
  end

  // Branch redirect: one-cycle flush pulse; target holds when not taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush  <= 1'b0;
      r_target <= '0;
    end else begin
      r_flush <= w_taken;
      if (w_taken) r_target <= w_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
// Multiply-specific scenarios are compiled only when EX_MUL_EN is defined;
// otherwise op 1010 is checked as a single-cycle op returning 0.
module tb_ex_stage;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  logic              RegWrite_i;
  logic              ALUSrc_i;
  logic              Branch_i;
  logic [3:0]        ALUControl_i;
  logic [31:0]       imme_i;
  logic [31:0]       rdata1_i;
  logic [31:0]       rdata2_i;
  logic [31:0]       instr_i;
  logic [ADDR_W-1:0] addr_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic              wb_regwrite_i;
  logic [4:0]        wb_rd_i;
  logic [31:0]       wb_wdata_i;
  logic              stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] branch_target_o;
  logic              valid_o;
  logic              RegWrite_o;
  logic [31:0]       alu_result_o;
  logic [31:0]       rdata2_o;
  logic [4:0]        rd_o;
  logic [31:0]       instr_o;

  int vectors;
  int miscompares;

  ex_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
    .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .ALUControl_i(ALUControl_i),
    .imme_i(imme_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .instr_i(instr_i),
    .addr_i(addr_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_wdata_i(wb_wdata_i),
    .stall_o(stall_o), .flush_o(flush_o), .branch_target_o(branch_target_o),
    .valid_o(valid_o), .RegWrite_o(RegWrite_o), .alu_result_o(alu_result_o),
    .rdata2_o(rdata2_o), .rd_o(rd_o), .instr_o(instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction on the ID/EX inputs (WB side left as is).
  task automatic present(input logic v, input logic [3:0] op, input logic regw,
                         input logic alusrc, input logic br, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ins, input logic [ADDR_W-1:0] addr,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    valid_i = v; ALUControl_i = op; RegWrite_i = regw; ALUSrc_i = alusrc;
    Branch_i = br; imme_i = imm; rdata1_i = a; rdata2_i = b; instr_i = ins;
    addr_i = addr; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_regwrite_i = 1'b0; wb_rd_i = 5'd0; wb_wdata_i = 32'd0;
    present(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 32'd4, 32'd0, '0, 5'd5, 5'd1, 5'd2);
    step();
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%b exp=0", valid_o);
    end
    vectors++;
    if (alu_result_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_result got=%h exp=0", alu_result_o);
    end
    vectors++;
    if (stall_o !== 1'b0 || flush_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall_flush got=%b%b exp=00", stall_o, flush_o);
    end
    vectors++;
    if (branch_target_o !== '0 || RegWrite_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_target_regw got=%h/%b exp=0/0", branch_target_o, RegWrite_o);
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    // ADD x5 = 3 + 4
    present(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 32'd4, 32'h11, '0, 5'd5, 5'd1, 5'd2);
    step();
    vectors++;
    if (valid_o !== 1'b1 || alu_result_o !== 32'd7 || rd_o !== 5'd5) begin
      miscompares++; $display("FAIL add_basic got=%b/%h/%0d exp=1/7/5", valid_o, alu_result_o, rd_o);
    end
    // SUB x6 = x5 - 1, rdata1 stale 0 -> EX/MEM forward
    present(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, 32'h22, '0, 5'd6, 5'd5, 5'd0);
    step();
    vectors++;
    if (alu_result_o !== 32'd6 || instr_o !== 32'h22) begin
      miscompares++; $display("FAIL fwd_exmem got=%h/%h exp=6/22", alu_result_o, instr_o);
    end
    // bubble
    present(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
    vectors++;
    if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || alu_result_o !== 32'd6) begin
      miscompares++; $display("FAIL bubble got=%b/%b/%h exp=0/0/6", valid_o, RegWrite_o, alu_result_o);
    end
    // SUB again, EX/MEM idle, WB supplies x5=10
    wb_regwrite_i = 1'b1; wb_rd_i = 5'd5; wb_wdata_i = 32'd10;
    present(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, 32'h33, '0, 5'd6, 5'd5, 5'd0);
    step();
    vectors++;
    if (alu_result_o !== 32'd9) begin
      miscompares++; $display("FAIL fwd_wb got=%h exp=9", alu_result_o);
    end
    // EX/MEM (x6=9) beats WB (x6=100) on rs1; rs2 also forwarded to store data
    wb_rd_i = 5'd6; wb_wdata_i = 32'd100;
    present(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd2, 32'h44, '0, 5'd7, 5'd6, 5'd6);
    step();
    vectors++;
    if (alu_result_o !== 32'd9 || rdata2_o !== 32'd9) begin
      miscompares++; $display("FAIL fwd_priority got=%h/%h exp=9/9", alu_result_o, rdata2_o);
    end
    // previous op had RegWrite=0: WB forwards x6=100 on rs2 now
    present(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd2, 32'h45, '0, 5'd7, 5'd0, 5'd6);
    step();
    vectors++;
    if (rdata2_o !== 32'd100) begin
      miscompares++; $display("FAIL fwd_wb_rs2 got=%h exp=64", rdata2_o);
    end
    // rs1=0 with wb_rd=0: no forwarding
    wb_rd_i = 5'd0; wb_wdata_i = 32'hFF;
    present(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 32'd1, 32'h11, 32'd0, 32'h55, '0, 5'd8, 5'd0, 5'd0);
    step();
    vectors++;
    if (alu_result_o !== 32'h12 || rdata2_o !== 32'd0) begin
      miscompares++; $display("FAIL fwd_x0 got=%h/%h exp=12/0", alu_result_o, rdata2_o);
    end
    wb_regwrite_i = 1'b0;
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
  endtask

  task automatic test_branch();
    // BEQ taken, target wraps 0x3FF0 + 0x20 -> 0x0010
    present(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 32'h20, 32'd5, 32'd5, 32'h00000063, 14'h3FF0, 5'd0, 5'd8, 5'd8);
    step();
    vectors++;
    if (flush_o !== 1'b1 || branch_target_o !== 14'h0010) begin
      miscompares++; $display("FAIL beq_taken got=%b/%h exp=1/0010", flush_o, branch_target_o);
    end
    // younger ADD in the flush cycle is squashed
    present(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1, 32'h0, '0, 5'd7, 5'd1, 5'd2);
    step();
    vectors++;
    if (valid_o !== 1'b0 || flush_o !== 1'b0) begin
      miscompares++; $display("FAIL squash got=%b/%b exp=0/0", valid_o, flush_o);
    end
    // BNE on equal operands: not taken, target holds
    present(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 32'h40, 32'd5, 32'd5, 32'h00001063, 14'h0200, 5'd0, 5'd8, 5'd8);
    step();
    vectors++;
    if (flush_o !== 1'b0 || branch_target_o !== 14'h0010) begin
      miscompares++; $display("FAIL bne_not_taken got=%b/%h exp=0/0010", flush_o, branch_target_o);
    end
    // BLT signed: -1 < 1 taken
    present(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h00004063, 14'h0100, 5'd0, 5'd8, 5'd13);
    step();
    vectors++;
    if (flush_o !== 1'b1 || branch_target_o !== 14'h0108) begin
      miscompares++; $display("FAIL blt_taken got=%b/%h exp=1/0108", flush_o, branch_target_o);
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
    // BLTU: 0xFFFFFFFF < 1 false -> not taken
    present(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h00006063, 14'h0300, 5'd0, 5'd8, 5'd13);
    step();
    vectors++;
    if (flush_o !== 1'b0 || branch_target_o !== 14'h0108) begin
      miscompares++; $display("FAIL bltu_not_taken got=%b/%h exp=0/0108", flush_o, branch_target_o);
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [11];
    logic [31:0] exps [11];
    ops[0] = 4'b0111; exps[0] = 32'd1;           // SLT
    ops[1] = 4'b1001; exps[1] = 32'd0;           // SLTU
    ops[2] = 4'b1000; exps[2] = 32'hC0000000;    // SRA
    ops[3] = 4'b0101; exps[3] = 32'h40000000;    // SRL
    ops[4] = 4'b0100; exps[4] = 32'h00000000;    // SLL
    ops[5] = 4'b0010; exps[5] = 32'h80000001;    // ADD
    ops[6] = 4'b0110; exps[6] = 32'h7FFFFFFF;    // SUB
    ops[7] = 4'b0000; exps[7] = 32'h00000000;    // AND
    ops[8] = 4'b0001; exps[8] = 32'h80000001;    // OR
    ops[9] = 4'b0011; exps[9] = 32'h80000001;    // XOR
    ops[10] = 4'b1011; exps[10] = 32'h00000000;  // unused encoding
    for (int i = 0; i < 11; i++) begin
      present(1'b1, ops[i], 1'b1, 1'b1, 1'b0, 32'd1, 32'h80000000, 32'd0, 32'd0, '0, 5'd10, 5'd9, 5'd0);
      step();
      vectors++;
      if (valid_o !== 1'b1 || alu_result_o !== exps[i]) begin
        miscompares++;
        $display("FAIL alu_op_%b got=%b/%h exp=1/%h", ops[i], valid_o, alu_result_o, exps[i]);
      end
    end
    // SLL with shift amount taken from B[4:0] only
    present(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 32'h24, 32'h1, 32'd0, 32'd0, '0, 5'd10, 5'd9, 5'd0);
    step();
    vectors++;
    if (alu_result_o !== 32'h10) begin
      miscompares++; $display("FAIL sll_shamt got=%h exp=10", alu_result_o);
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int n_stall;
    int edges;
    n_stall = 0;
    edges = 0;
    present(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd3, 32'h77, '0, 5'd12, 5'd11, 5'd14);
    #1;
    if (stall_o === 1'b1) n_stall++;
    while (edges < 100) begin
      step();
      edges++;
      // garbage on the inputs while the multiply is running
      present(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1234, 32'h5678, 32'h99, '0, 5'd3, 5'd1, 5'd2);
      #1;
      if (valid_o === 1'b1) break;
      if (stall_o === 1'b1) n_stall++;
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    vectors++;
    if (n_stall != 33) begin
      miscompares++; $display("FAIL mul_stall_cycles got=%0d exp=33", n_stall);
    end
    vectors++;
    if (edges != 34) begin
      miscompares++; $display("FAIL mul_latency got=%0d exp=34", edges);
    end
    vectors++;
    if (valid_o !== 1'b1 || alu_result_o !== 32'hFFFFFFFD || rd_o !== 5'd12) begin
      miscompares++; $display("FAIL mul_result got=%b/%h/%0d exp=1/fffffffd/12", valid_o, alu_result_o, rd_o);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int seen_valid;
    seen_valid = 0;
    present(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd7, 32'd9, 32'h88, '0, 5'd12, 5'd11, 5'd14);
    step();
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (stall_o !== 1'b0 || valid_o !== 1'b0) begin
      miscompares++; $display("FAIL mid_mul_reset got=%b/%b exp=0/0", stall_o, valid_o);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o === 1'b1 || stall_o === 1'b1) seen_valid++;
    end
    vectors++;
    if (seen_valid != 0) begin
      miscompares++; $display("FAIL mid_mul_no_result got=%0d exp=0", seen_valid);
    end
  endtask
`else
  task automatic test_mul();
    present(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd3, 32'h77, '0, 5'd12, 5'd11, 5'd14);
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++; $display("FAIL mul_no_stall got=%b exp=0", stall_o);
    end
    step();
    vectors++;
    if (valid_o !== 1'b1 || alu_result_o !== 32'd0 || rd_o !== 5'd12) begin
      miscompares++; $display("FAIL mul_single_cycle got=%b/%h/%0d exp=1/0/12", valid_o, alu_result_o, rd_o);
    end
    present(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 5'd0, 5'd0, 5'd0);
    step();
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_branch();
    test_alu_ops();
    test_mul();
`ifdef EX_MUL_EN
    test_reset_mid_mul();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
